// File: rtl/udc_fsm.sv
// Up/down occupancy counter: synchronised active-low arrival/departure sensors,
// saturating count with EMPTY/PARTIAL/FULL state and registered full/empty flags.
module udc_fsm #(
    parameter int CNT_W       = 3,
    parameter int MAX_COUNT   = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sens_front,
    input  logic             sens_back,
    output logic             fflag,
    output logic             eflag,
    output logic [CNT_W-1:0] p_count
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

    logic [SYNC_STAGES-1:0] front_sync_q;
    logic [SYNC_STAGES-1:0] back_sync_q;
    logic                   front_hist_q;
    logic                   back_hist_q;
    logic                   front_evt_s;
    logic                   back_evt_s;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fflag_q;
    logic             eflag_q;

    // Sensor synchronisers and edge history; preset to the idle-high level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_sync_q <= {SYNC_STAGES{1'b1}};
            back_sync_q  <= {SYNC_STAGES{1'b1}};
            front_hist_q <= 1'b1;
            back_hist_q  <= 1'b1;
        end else begin
            front_sync_q <= {front_sync_q[SYNC_STAGES-2:0], sens_front};
            back_sync_q  <= {back_sync_q[SYNC_STAGES-2:0], sens_back};
            front_hist_q <= front_sync_q[SYNC_STAGES-1];
            back_hist_q  <= back_sync_q[SYNC_STAGES-1];
        end
    end

    assign front_evt_s = front_hist_q & ~front_sync_q[SYNC_STAGES-1];
    assign back_evt_s  = back_hist_q & ~back_sync_q[SYNC_STAGES-1];

    // Next state and count; simultaneous events cancel and leave everything held.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_EMPTY: begin
                if (front_evt_s && !back_evt_s) begin
                    count_d = CNT_ONE;
                    state_d = (CNT_ONE == CNT_MAX) ? ST_FULL : ST_PARTIAL;
                end else begin
                    count_d = CNT_ZERO;
                end
            end
            ST_PARTIAL: begin
                if (front_evt_s && !back_evt_s) begin
                    count_d = count_q + CNT_ONE;
                    state_d = ((count_q + CNT_ONE) == CNT_MAX) ? ST_FULL : ST_PARTIAL;
                end else if (back_evt_s && !front_evt_s) begin
                    count_d = count_q - CNT_ONE;
                    state_d = (count_q == CNT_ONE) ? ST_EMPTY : ST_PARTIAL;
                end else begin
                    count_d = count_q;
                end
            end
            ST_FULL: begin
                if (back_evt_s && !front_evt_s) begin
                    count_d = CNT_MAX - CNT_ONE;
                    state_d = (CNT_MAX == CNT_ONE) ? ST_EMPTY : ST_PARTIAL;
                end else begin
                    count_d = CNT_MAX;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                count_d = CNT_ZERO;
            end
        endcase
    end

    // State, count and flags registered together so flags track p_count exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            count_q <= CNT_ZERO;
            fflag_q <= 1'b0;
            eflag_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            fflag_q <= (state_d == ST_FULL);
            eflag_q <= (state_d == ST_EMPTY);
        end
    end

    assign p_count = count_q;
    assign fflag   = fflag_q;
    assign eflag   = eflag_q;

endmodule

// File: tb/tb_udc_fsm.sv
// Scoreboard bench for udc_fsm: expected counts queued as sensor edges are driven,
// popped and compared once the three-edge latency has elapsed.
module tb_udc_fsm;

    logic       clk;
    logic       rst;
    logic       sens_front;
    logic       sens_back;
    logic       fflag;
    logic       eflag;
    logic [2:0] p_count;

    int errors;
    int checks;
    int model_count;
    int exp_q[$];

    udc_fsm #(.CNT_W(3), .MAX_COUNT(7), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sens_front (sens_front),
        .sens_back  (sens_back),
        .fflag      (fflag),
        .eflag      (eflag),
        .p_count    (p_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sensor event (front, back or both) held low for low_cycles, then high for 4.
    task automatic do_event(input bit f, input bit b, input int low_cycles, input string name);
        int prev;
        int exp;
        @(negedge clk);
        if (f) sens_front = 1'b0;
        if (b) sens_back  = 1'b0;
        prev = model_count;
        if (f && !b && model_count < 7) model_count++;
        if (b && !f && model_count > 0) model_count--;
        exp_q.push_back(model_count);
        repeat (2) @(negedge clk);
        checks++;
        if (p_count !== 3'(prev)) begin
            errors++;
            $display("FAIL %s_latency: p_count=%0d expected %0d", name, p_count, prev);
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_scoreboard: queue empty", name);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (p_count !== 3'(exp)) begin
                errors++;
                $display("FAIL %s_count: p_count=%0d expected %0d", name, p_count, exp);
            end
            checks++;
            if (fflag !== (exp == 7) || eflag !== (exp == 0)) begin
                errors++;
                $display("FAIL %s_flags: fflag=%0b eflag=%0b expected %0b %0b",
                         name, fflag, eflag, (exp == 7), (exp == 0));
            end
        end
        repeat (low_cycles - 3) @(negedge clk);
        sens_front = 1'b1;
        sens_back  = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (p_count !== 3'(model_count)) begin
            errors++;
            $display("FAIL %s_stable: p_count=%0d expected %0d", name, p_count, model_count);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        sens_front = 1'b1;
        sens_back  = 1'b1;
        model_count = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (p_count !== 3'd0 || eflag !== 1'b1 || fflag !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: p_count=%0d eflag=%0b fflag=%0b expected 0 1 0", p_count, eflag, fflag);
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (p_count !== 3'd0 || eflag !== 1'b1 || fflag !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: p_count=%0d eflag=%0b fflag=%0b expected 0 1 0", p_count, eflag, fflag);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) do_event(1'b1, 1'b0, 4, "fill");
    endtask

    task automatic test_overflow();
        do_event(1'b1, 1'b0, 4, "overflow");
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) do_event(1'b0, 1'b1, 4, "drain");
    endtask

    task automatic test_long_and_simultaneous();
        do_event(1'b1, 1'b0, 4, "to2");
        do_event(1'b1, 1'b0, 4, "to2");
        do_event(1'b1, 1'b0, 50, "long");
        do_event(1'b1, 1'b1, 4, "both_at3");
        for (int i = 0; i < 3; i++) do_event(1'b0, 1'b1, 4, "to0");
        do_event(1'b1, 1'b1, 4, "both_at0");
        for (int i = 0; i < 7; i++) do_event(1'b1, 1'b0, 4, "to7");
        do_event(1'b1, 1'b1, 4, "both_at7");
    endtask

    task automatic test_reset_mid();
        do_event(1'b0, 1'b1, 4, "to5");
        do_event(1'b0, 1'b1, 4, "to5");
        checks++;
        if (p_count !== 3'd5) begin
            errors++;
            $display("FAIL mid_pre: p_count=%0d expected 5", p_count);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_count = 0;
        #1;
        checks++;
        if (p_count !== 3'd0 || eflag !== 1'b1 || fflag !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: p_count=%0d eflag=%0b fflag=%0b expected 0 1 0", p_count, eflag, fflag);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (p_count !== 3'd0 || eflag !== 1'b1 || fflag !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: p_count=%0d eflag=%0b fflag=%0b expected 0 1 0", p_count, eflag, fflag);
        end
        do_event(1'b1, 1'b0, 4, "after_reset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_long_and_simultaneous();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
